// File: rtl/lock_ctrl_param.sv
// Parametrised keypad lock: multi-digit entry with failure counting, timed intruder
// lockout, auto-relock after inactivity and in-place password change while open.
module lock_ctrl_param #(
    parameter int                            DIGIT_W        = 4,
    parameter int                            NUM_DIGITS     = 4,
    parameter logic [DIGIT_W*NUM_DIGITS-1:0] DEFAULT_PWD    = 16'h1234,
    parameter int                            MAX_ATTEMPTS   = 3,
    parameter int                            LOCKOUT_CYCLES = 1000,
    parameter int                            UNLOCK_CYCLES  = 500,
    parameter int                            ENTRY_TIMEOUT  = 200
) (
    input  logic                              clk,
    input  logic                              rst_btn,
    input  logic [DIGIT_W-1:0]                digit_in,
    input  logic                              digit_valid,
    input  logic                              clear_btn,
    input  logic                              lock_btn,
    input  logic                              set_pwd_btn,
    output logic                              led_locked,
    output logic                              led_unlocked,
    output logic                              led_alert,
    output logic [$clog2(MAX_ATTEMPTS+1)-1:0] fail_count,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_count
);
    localparam int PW     = DIGIT_W * NUM_DIGITS;
    localparam int FCW    = $clog2(MAX_ATTEMPTS + 1);
    localparam int DCW    = $clog2(NUM_DIGITS + 1);
    localparam int TMAX_A = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ? LOCKOUT_CYCLES : UNLOCK_CYCLES;
    localparam int TMAX   = (TMAX_A > ENTRY_TIMEOUT) ? TMAX_A : ENTRY_TIMEOUT;
    localparam int TW     = $clog2(TMAX + 1);

    typedef enum logic [2:0] {S_LOCKED, S_ENTRY, S_UNLOCKED, S_SET_PWD, S_ALERT} state_t;

    state_t         state, state_n;
    logic [PW-1:0]  buffer, buffer_n, pwd, pwd_n, buf_sh;
    logic [FCW-1:0] fail_n;
    logic [DCW-1:0] dcnt_n;
    logic [TW-1:0]  timer, timer_n, timer_inc;
    logic           digit_ok, last_digit, open_n;

    // One shared timer serves entry idle, unlock idle and lockout; every exit clears it.
    assign timer_inc  = (timer == TW'(TMAX)) ? timer : timer + 1'b1;
    assign buf_sh     = (buffer << DIGIT_W) | PW'(digit_in);
    assign digit_ok   = digit_valid && !clear_btn && !lock_btn && !set_pwd_btn;
    assign last_digit = (digit_count == DCW'(NUM_DIGITS - 1));
    assign open_n     = (state_n == S_UNLOCKED) || (state_n == S_SET_PWD);

    always_comb begin
        state_n  = state;
        buffer_n = buffer;
        pwd_n    = pwd;
        fail_n   = fail_count;
        dcnt_n   = digit_count;
        timer_n  = timer_inc;
        case (state)
            S_LOCKED, S_ENTRY: begin
                if (clear_btn) begin
                    state_n = S_LOCKED;
                    dcnt_n  = '0;
                    timer_n = '0;
                end else if (digit_ok) begin
                    buffer_n = buf_sh;
                    timer_n  = '0;
                    if (last_digit) begin
                        dcnt_n = '0;
                        if (buf_sh == pwd) begin
                            state_n = S_UNLOCKED;
                            fail_n  = '0;
                        end else if (int'(fail_count) + 1 >= MAX_ATTEMPTS) begin
                            state_n = S_ALERT;
                            fail_n  = FCW'(MAX_ATTEMPTS);
                        end else begin
                            state_n = S_LOCKED;
                            fail_n  = fail_count + 1'b1;
                        end
                    end else begin
                        state_n = S_ENTRY;
                        dcnt_n  = digit_count + 1'b1;
                    end
                end else if (state == S_LOCKED) begin
                    timer_n = '0;
                end else if (timer == TW'(ENTRY_TIMEOUT - 1)) begin
                    state_n = S_LOCKED;
                    dcnt_n  = '0;
                    timer_n = '0;
                end
            end
            S_UNLOCKED: begin
                if (lock_btn || timer == TW'(UNLOCK_CYCLES - 1)) begin
                    state_n = S_LOCKED;
                    timer_n = '0;
                end else if (set_pwd_btn) begin
                    state_n = S_SET_PWD;
                    dcnt_n  = '0;
                    timer_n = '0;
                end
            end
            S_SET_PWD: begin
                if (clear_btn) begin
                    state_n = S_UNLOCKED;
                    dcnt_n  = '0;
                    timer_n = '0;
                end else if (lock_btn) begin
                    state_n = S_LOCKED;
                    dcnt_n  = '0;
                    timer_n = '0;
                end else if (digit_ok) begin
                    buffer_n = buf_sh;
                    timer_n  = '0;
                    if (last_digit) begin
                        pwd_n   = buf_sh;
                        state_n = S_UNLOCKED;
                        dcnt_n  = '0;
                    end else begin
                        dcnt_n = digit_count + 1'b1;
                    end
                end else if (timer == TW'(ENTRY_TIMEOUT - 1)) begin
                    state_n = S_UNLOCKED;
                    dcnt_n  = '0;
                    timer_n = '0;
                end
            end
            S_ALERT: begin
                if (timer == TW'(LOCKOUT_CYCLES - 1)) begin
                    state_n = S_LOCKED;
                    fail_n  = '0;
                    timer_n = '0;
                end
            end
            default: begin
                state_n = S_LOCKED;
                dcnt_n  = '0;
                timer_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_btn) begin
            state        <= S_LOCKED;
            buffer       <= '0;
            pwd          <= DEFAULT_PWD;
            fail_count   <= '0;
            digit_count  <= '0;
            timer        <= '0;
            led_locked   <= 1'b1;
            led_unlocked <= 1'b0;
            led_alert    <= 1'b0;
        end else begin
            state        <= state_n;
            buffer       <= buffer_n;
            pwd          <= pwd_n;
            fail_count   <= fail_n;
            digit_count  <= dcnt_n;
            timer        <= timer_n;
            led_locked   <= !open_n;
            led_unlocked <= open_n;
            led_alert    <= (state_n == S_ALERT);
        end
    end
endmodule

// File: tb/tb_lock_ctrl_param.sv
// Bench for lock_ctrl_param: directed scenarios with literal expectations, then
// random keypad traffic compared every cycle against a queue-based behavioural model.
module tb_lock_ctrl_param;
    localparam int          DW   = 4;
    localparam int          ND   = 4;
    localparam int          MAXA = 3;
    localparam int          LO   = 20;
    localparam int          UC   = 30;
    localparam int          ET   = 10;
    localparam logic [15:0] DEF  = 16'h1234;

    logic       clk = 1'b0;
    logic       rst_btn = 1'b0;
    logic [3:0] digit_in = '0;
    logic       digit_valid = 1'b0, clear_btn = 1'b0, lock_btn = 1'b0, set_pwd_btn = 1'b0;
    logic       led_locked, led_unlocked, led_alert;
    logic [1:0] fail_count;
    logic [2:0] digit_count;

    always #5 clk = ~clk;

    lock_ctrl_param #(
        .DIGIT_W(DW), .NUM_DIGITS(ND), .DEFAULT_PWD(DEF), .MAX_ATTEMPTS(MAXA),
        .LOCKOUT_CYCLES(LO), .UNLOCK_CYCLES(UC), .ENTRY_TIMEOUT(ET)
    ) dut (
        .clk(clk), .rst_btn(rst_btn), .digit_in(digit_in), .digit_valid(digit_valid),
        .clear_btn(clear_btn), .lock_btn(lock_btn), .set_pwd_btn(set_pwd_btn),
        .led_locked(led_locked), .led_unlocked(led_unlocked), .led_alert(led_alert),
        .fail_count(fail_count), .digit_count(digit_count)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: digits held in a queue, the open/alert situation as flags,
    // and countdowns/ages as plain integers.
    logic [15:0] m_pwd = DEF;
    int          m_fails = 0;
    int          m_q[$];
    bit          m_unl = 0, m_set = 0, m_alert = 0, m_valid = 0;
    int          m_age = 0, m_alert_left = 0;

    function automatic logic [15:0] q_value();
        logic [15:0] v = '0;
        foreach (m_q[i]) v = (v << DW) | 16'(m_q[i]);
        return v;
    endfunction

    always @(posedge clk) begin
        bit          dig;
        logic [15:0] v;
        dig = digit_valid && !clear_btn && !lock_btn && !set_pwd_btn;
        if (!rst_btn) begin
            m_pwd = DEF; m_fails = 0; m_q.delete();
            m_unl = 0; m_set = 0; m_alert = 0; m_age = 0; m_valid = 1;
        end else if (m_alert) begin
            m_alert_left--;
            if (m_alert_left == 0) begin m_alert = 0; m_fails = 0; end
        end else if (m_unl && !m_set) begin
            m_age++;
            if (lock_btn || m_age >= UC) m_unl = 0;
            else if (set_pwd_btn) begin m_set = 1; m_q.delete(); m_age = 0; end
        end else if (m_set) begin
            if (clear_btn) begin m_set = 0; m_q.delete(); m_age = 0; end
            else if (lock_btn) begin m_set = 0; m_unl = 0; m_q.delete(); end
            else if (dig) begin
                m_q.push_back(int'(digit_in)); m_age = 0;
                if (m_q.size() == ND) begin m_pwd = q_value(); m_q.delete(); m_set = 0; end
            end else begin
                m_age++;
                if (m_age >= ET) begin m_set = 0; m_q.delete(); m_age = 0; end
            end
        end else begin
            if (clear_btn) m_q.delete();
            else if (dig) begin
                m_q.push_back(int'(digit_in)); m_age = 0;
                if (m_q.size() == ND) begin
                    v = q_value(); m_q.delete();
                    if (v == m_pwd) begin m_unl = 1; m_fails = 0; end
                    else begin
                        m_fails++;
                        if (m_fails >= MAXA) begin m_alert = 1; m_alert_left = LO; end
                    end
                end
            end else if (m_q.size() > 0) begin
                m_age++;
                if (m_age >= ET) m_q.delete();
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("led_locked", 32'(led_locked), 32'(!m_unl));
            chk("led_unlocked", 32'(led_unlocked), 32'(m_unl));
            chk("led_alert", 32'(led_alert), 32'(m_alert));
            chk("fail_count", 32'(fail_count), 32'(m_fails));
            chk("digit_count", 32'(digit_count), 32'(m_q.size()));
        end
    end

    task automatic tick(input bit r, input bit dv, input logic [3:0] d,
                        input bit clr, input bit lk, input bit sp);
        rst_btn = r; digit_valid = dv; digit_in = d;
        clear_btn = clr; lock_btn = lk; set_pwd_btn = sp;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1, 0, 4'h0, 0, 0, 0);
    endtask

    task automatic key(input logic [3:0] d);
        tick(1, 1, d, 0, 0, 0);
    endtask

    task automatic enter(input logic [15:0] code);
        for (int i = 3; i >= 0; i--) key(code[i*4 +: 4]);
    endtask

    initial begin
        tick(0, 0, 4'h0, 0, 0, 0);
        tick(0, 0, 4'h0, 0, 0, 0);
        chk("rst_locked", 32'(led_locked), 32'd1);
        chk("rst_unlocked", 32'(led_unlocked), 32'd0);
        chk("rst_alert", 32'(led_alert), 32'd0);
        chk("rst_fail", 32'(fail_count), 32'd0);
        chk("rst_dcnt", 32'(digit_count), 32'd0);

        key(4'h1); key(4'h2); key(4'h3);
        chk("dcnt_3", 32'(digit_count), 32'd3);
        chk("locked_mid_entry", 32'(led_locked), 32'd1);
        key(4'h4);
        chk("unlock_1234", 32'(led_unlocked), 32'd1);
        chk("unlock_dcnt", 32'(digit_count), 32'd0);
        idle(UC - 1);
        chk("still_open_29", 32'(led_unlocked), 32'd1);
        idle(1);
        chk("relock_30", 32'(led_locked), 32'd1);

        enter(16'h1000); chk("fail_1", 32'(fail_count), 32'd1);
        enter(16'h1000); chk("fail_2", 32'(fail_count), 32'd2);
        enter(16'h1000);
        chk("alert_on", 32'(led_alert), 32'd1);
        chk("alert_fail", 32'(fail_count), 32'd3);
        enter(16'h1234);
        chk("alert_ignores", 32'(led_unlocked), 32'd0);
        idle(LO - 5);
        chk("alert_19", 32'(led_alert), 32'd1);
        idle(1);
        chk("alert_off_20", 32'(led_alert), 32'd0);
        chk("alert_fail_clr", 32'(fail_count), 32'd0);
        enter(16'h1234);
        chk("unlock_after_alert", 32'(led_unlocked), 32'd1);

        tick(1, 0, 4'h0, 0, 0, 1);
        enter(16'hABCD);
        chk("setpwd_open", 32'(led_unlocked), 32'd1);
        tick(1, 0, 4'h0, 0, 1, 0);
        chk("lock_btn", 32'(led_locked), 32'd1);
        enter(16'h1234);
        chk("old_pwd_fails", 32'(fail_count), 32'd1);
        enter(16'hABCD);
        chk("new_pwd_opens", 32'(led_unlocked), 32'd1);
        chk("new_pwd_fail0", 32'(fail_count), 32'd0);

        tick(1, 0, 4'h0, 0, 1, 0);
        enter(16'h1111);
        key(4'h1); key(4'h2);
        idle(ET - 1);
        chk("timeout_not_yet", 32'(digit_count), 32'd2);
        idle(1);
        chk("timeout_dcnt", 32'(digit_count), 32'd0);
        chk("timeout_fail_kept", 32'(fail_count), 32'd1);
        key(4'h7);
        tick(1, 1, 4'h8, 1, 0, 0);
        chk("clear_mid", 32'(digit_count), 32'd0);
        tick(1, 1, 4'h8, 1, 0, 0);
        chk("clear_drops_digit", 32'(digit_count), 32'd0);

        enter(16'h1111);
        chk("fail_2b", 32'(fail_count), 32'd2);
        key(4'h5); key(4'h5);
        tick(0, 1, 4'h5, 0, 0, 0);
        chk("midrst_locked", 32'(led_locked), 32'd1);
        chk("midrst_fail", 32'(fail_count), 32'd0);
        chk("midrst_dcnt", 32'(digit_count), 32'd0);
        enter(16'h1234);
        chk("pwd_restored", 32'(led_unlocked), 32'd1);

        tick(1, 0, 4'h0, 0, 1, 1);
        chk("lock_beats_set", 32'(led_locked), 32'd1);
        enter(16'h1234);
        chk("pwd_unchanged", 32'(led_unlocked), 32'd1);

        for (int it = 0; it < 2500; it++) begin
            int         r;
            logic [3:0] d;
            bit         dv;
            r = int'($urandom_range(0, 99));
            if (r < 4) begin
                idle(int'($urandom_range(5, 35)));
            end else begin
                if ($urandom_range(0, 3) == 0 || m_q.size() >= ND)
                    d = 4'($urandom_range(0, 15));
                else
                    d = 4'(m_pwd >> (DW * (ND - 1 - m_q.size())));
                dv = (r < 55) || (r < 70 && $urandom_range(0, 1) == 1);
                tick(r != 70, dv, d, r >= 55 && r < 60, r >= 60 && r < 65, r >= 65 && r < 70);
            end
        end

        tick(1, 0, 4'h0, 0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/lock_ctrl_param.md
Name: lock_ctrl_param

Overview:
- Parametrised successor of the single-shot 4-bit lock.
- Accepts a multi-digit password one digit per strobe and counts failed attempts.
- Enters a timed intruder-alert lockout after MAX_ATTEMPTS failures, then auto-resets.
- Auto-relocks after an unlock timeout, and lets the user change the password while unlocked.
- Sits between the keypad debouncer/encoder and the LED/status outputs of the lock top level.

Parameters:
- DIGIT_W, 4, bits per entered digit.
- NUM_DIGITS, 4, digits per password.
- DEFAULT_PWD, 16'h1234, password loaded at reset. Width is DIGIT_W*NUM_DIGITS; first-entered digit is the MS digit.
- MAX_ATTEMPTS, 3, consecutive failures that trigger ALERT (>=1).
- LOCKOUT_CYCLES, 1000, cycles spent in ALERT before auto-reset (>=1).
- UNLOCK_CYCLES, 500, cycles in UNLOCKED without activity before auto-relock (>=1).
- ENTRY_TIMEOUT, 200, max idle cycles between digits before a partial entry is discarded (>=1).

Ports:
- clk, input, 1: system clock, rising edge.
- rst_btn, input, 1: synchronous, active-low reset.
- digit_in, input, DIGIT_W: keypad digit.
- digit_valid, input, 1: single-cycle strobe qualifying digit_in.
- clear_btn, input, 1: discard partial entry.
- lock_btn, input, 1: relock immediately from UNLOCKED.
- set_pwd_btn, input, 1: enter password-change mode from UNLOCKED.
- led_locked, output, 1: lock is closed.
- led_unlocked, output, 1: lock is open.
- led_alert, output, 1: intruder alert active.
- fail_count, output, $clog2(MAX_ATTEMPTS+1): consecutive failures.
- digit_count, output, $clog2(NUM_DIGITS+1): digits held in the current entry.

Behaviour:
- All outputs are registered and all state changes occur on the rising clk edge.
- Reset (rst_btn=0 at an edge):
  - state=LOCKED, password register=DEFAULT_PWD, entry buffer=0.
  - fail_count=0, digit_count=0, all timers=0.
  - led_locked=1, led_unlocked=0, led_alert=0.
  - Reset wins over every other input in every state, including mid-entry and ALERT.
- Input priority, highest first: rst_btn, clear_btn, lock_btn, set_pwd_btn, digit_valid. A digit_valid coincident with a higher-priority input is dropped.
- LOCKED:
  - Outputs: led_locked=1, led_unlocked=0, led_alert=0.
  - digit_valid: shift digit into the buffer, digit_count=1, go to ENTRY.
  - lock_btn and set_pwd_btn are ignored.
- ENTRY:
  - Outputs: led_locked=1, led_unlocked=0, led_alert=0.
  - Each digit_valid shifts the digit in, increments digit_count and clears the idle timer.
  - On the edge that accepts digit NUM_DIGITS, the full buffer (including that digit) is compared with the password. Result is visible after that same edge (0 extra cycles).
  - Match: go to UNLOCKED, fail_count=0.
  - Mismatch and fail_count+1 < MAX_ATTEMPTS: fail_count+1, go to LOCKED.
  - Mismatch and fail_count+1 = MAX_ATTEMPTS: fail_count=MAX_ATTEMPTS, go to ALERT.
  - digit_count returns to 0 in all three cases.
  - clear_btn, or idle timer reaching ENTRY_TIMEOUT: go to LOCKED, digit_count=0, fail_count unchanged (not a failed attempt).
- UNLOCKED:
  - Outputs: led_locked=0, led_unlocked=1, led_alert=0.
  - Idle timer counts every cycle.
  - lock_btn, or timer reaching UNLOCK_CYCLES: go to LOCKED.
  - set_pwd_btn: go to SET_PWD, digit_count=0.
  - digit_valid is ignored.
- SET_PWD:
  - Outputs: led_locked=0, led_unlocked=1, led_alert=0.
  - Digits are collected as in ENTRY.
  - On digit NUM_DIGITS: password register := buffer, return to UNLOCKED with the timer reset.
  - clear_btn, or ENTRY_TIMEOUT: return to UNLOCKED, password unchanged.
  - lock_btn: go to LOCKED, password unchanged.
- ALERT:
  - Outputs: led_locked=1, led_unlocked=0, led_alert=1.
  - All inputs except rst_btn are ignored.
  - After exactly LOCKOUT_CYCLES cycles in ALERT: fail_count=0, go to LOCKED, led_alert=0.
- Timers saturate and are never allowed to wrap.
- Buffer shift: buffer = {buffer[lower bits], digit_in}; the first-entered digit ends up MS.
- Exactly one of led_locked/led_unlocked is 1 at all times.

Test Plan (NUM_DIGITS=4, MAX_ATTEMPTS=3, LOCKOUT_CYCLES=20, UNLOCK_CYCLES=30, ENTRY_TIMEOUT=10):
- Reset, then digits 1,2,3,4 → led_unlocked=1 on the edge after the 4th digit; fail_count=0; 30 idle cycles later led_locked=1.
- Three entries of 1,0,0,0 → fail_count 1, then 2, then ALERT with led_alert=1. Digits 1,2,3,4 during ALERT are ignored. Exactly 20 cycles later led_alert=0, fail_count=0, and 1,2,3,4 then unlocks.
- Unlock, set_pwd_btn, digits A,B,C,D → stays unlocked; lock_btn; 1,2,3,4 fails with fail_count=1; A,B,C,D unlocks.
- Digits 1,2 then 10 idle cycles → digit_count=0, fail_count unchanged; clear_btn with a coincident digit_valid → digit dropped.
- Two failures, then rst_btn=0 mid-entry (after digits 5,5) → LOCKED, fail_count=0, password back to 16'h1234.
- Unlock, lock_btn and set_pwd_btn asserted in the same cycle → LOCKED (lock_btn wins); password unchanged.
